// File: rtl/arc_bus_pkg.sv
// arc_bus_pkg: shared types and constants for the ARC memory arbiter.
//   - arb_state_e : access sequencer states (2-bit)
//   - AwDefault / DwDefault : default address / data widths
//   - CntW : width of the memory wait-state counter
package arc_bus_pkg;

  localparam int unsigned AwDefault = 32;
  localparam int unsigned DwDefault = 32;
  localparam int unsigned CntW      = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
// Ports:
//   req        - request vector, bit i = master i
//   last_grant - index of the master granted most recently
//   grant      - one-hot grant (zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    // On a tie the master that did not win last time goes next.
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/arc_mem_arbiter.sv
// arc_mem_arbiter: shares one single-port memory between the ARC datapath (m0) and the
// UART loader (m1). One access in flight at a time, round-robin on ties, fixed wait states.
// Ports:
//   clk, rst                 - system clock, synchronous active-low reset
//   mN_req/we/addr/wdata     - master N request (held until ack), direction, address, data
//   mN_rdata, mN_ack         - master N registered read data, one-cycle completion pulse
//   mem_en/we/addr/wdata     - memory strobe (one cycle per access) and latched access fields
//   mem_rdata                - memory read data
//   busy                     - an access is being sequenced
module arc_mem_arbiter
  import arc_bus_pkg::*;
#(
  parameter int unsigned AW       = AwDefault,
  parameter int unsigned DW       = DwDefault,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam bit            HasWait  = (MEM_WAIT != 0);
  localparam logic [CntW-1:0] WaitLoad = CntW'(HasWait ? MEM_WAIT - 1 : 0);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_grant_q;
  logic [1:0]      grant;
  logic            mem_en_q, mem_we_q, busy_q, m0_ack_q, m1_ack_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q, m0_rdata_q, m1_rdata_q;

  rr_arb2 u_arb (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) state_d = StIssue;
      end
      StIssue: begin
        if (HasWait) begin
          state_d = StWait;
          cnt_d   = WaitLoad;
        end else begin
          state_d = StResp;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  // last_grant_q doubles as the owner of the in-flight access.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_en_q <= (state_d == StIssue);
      busy_q   <= (state_d != StIdle);
      m0_ack_q <= (state_d == StResp) && !last_grant_q;
      m1_ack_q <= (state_d == StResp) && last_grant_q;

      if (state_q == StIdle) begin
        unique case (grant)
          2'b01: begin
            last_grant_q <= 1'b0;
            mem_we_q     <= m0_we;
            mem_addr_q   <= m0_addr;
            mem_wdata_q  <= m0_wdata;
          end
          2'b10: begin
            last_grant_q <= 1'b1;
            mem_we_q     <= m1_we;
            mem_addr_q   <= m1_addr;
            mem_wdata_q  <= m1_wdata;
          end
          default: ;
        endcase
      end

      // Read data is captured on entry to RESP so it is valid alongside the ack.
      if (state_d == StResp && !mem_we_q) begin
        if (last_grant_q) begin
          m1_rdata_q <= mem_rdata;
        end else begin
          m0_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_arc_mem_arbiter.sv
// Bench for arc_mem_arbiter: three instances (MEM_WAIT = 1, 0, 2) checked every cycle against
// a timeline model, plus directed scenarios with literal expectations.
module tb_arc_mem_arbiter;

  localparam int NInst = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0 [NInst];
  logic        req1 [NInst];
  logic        we0  [NInst];
  logic        we1  [NInst];
  logic [31:0] addr0 [NInst];
  logic [31:0] addr1 [NInst];
  logic [31:0] wdata0 [NInst];
  logic [31:0] wdata1 [NInst];
  logic [31:0] rdata0 [NInst];
  logic [31:0] rdata1 [NInst];
  logic        ack0 [NInst];
  logic        ack1 [NInst];
  logic        mem_en [NInst];
  logic        mem_we [NInst];
  logic [31:0] mem_addr [NInst];
  logic [31:0] mem_wdata [NInst];
  logic [31:0] mem_rdata [NInst];
  logic        busy [NInst];

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A_0000) + 32'h1;
  endfunction

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    assign mem_rdata[g] = mem_fn(mem_addr[g]);
    arc_mem_arbiter #(
      .AW       (32),
      .DW       (32),
      .MEM_WAIT (g == 0 ? 1 : (g == 1 ? 0 : 2))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (req0[g]),
      .m0_we     (we0[g]),
      .m0_addr   (addr0[g]),
      .m0_wdata  (wdata0[g]),
      .m0_rdata  (rdata0[g]),
      .m0_ack    (ack0[g]),
      .m1_req    (req1[g]),
      .m1_we     (we1[g]),
      .m1_addr   (addr1[g]),
      .m1_wdata  (wdata1[g]),
      .m1_rdata  (rdata1[g]),
      .m1_ack    (ack1[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: e = cycles since grant (0 = idle). Cycle 1 strobes memory, cycle W+2 acks.
  int          e     [NInst];
  logic        own   [NInst];
  logic        x_we  [NInst];
  logic [31:0] x_addr [NInst];
  logic [31:0] x_wdata [NInst];
  logic [31:0] x_rd0 [NInst];
  logic [31:0] x_rd1 [NInst];

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NInst; k++) begin
      if (!rst) begin
        e[k] = 0; own[k] = 1'b1; x_we[k] = 1'b0;
        x_addr[k] = '0; x_wdata[k] = '0; x_rd0[k] = '0; x_rd1[k] = '0;
      end else if (e[k] == 0) begin
        if (req0[k] || req1[k]) begin
          own[k]     = (req0[k] && req1[k]) ? ~own[k] : req1[k];
          x_we[k]    = own[k] ? we1[k] : we0[k];
          x_addr[k]  = own[k] ? addr1[k] : addr0[k];
          x_wdata[k] = own[k] ? wdata1[k] : wdata0[k];
          e[k]       = 1;
        end
      end else if (e[k] == wait_of(k) + 2) begin
        e[k] = 0;
      end else begin
        e[k]++;
        if (e[k] == wait_of(k) + 2 && !x_we[k]) begin
          if (own[k]) x_rd1[k] = mem_fn(x_addr[k]);
          else        x_rd0[k] = mem_fn(x_addr[k]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      for (int k = 0; k < NInst; k++) begin
        int fin;
        fin = wait_of(k) + 2;
        chk($sformatf("mem_en[%0d]", k), 32'(mem_en[k]), 32'(e[k] == 1));
        chk($sformatf("mem_we[%0d]", k), 32'(mem_we[k]), 32'(x_we[k]));
        chk($sformatf("mem_addr[%0d]", k), mem_addr[k], x_addr[k]);
        chk($sformatf("mem_wdata[%0d]", k), mem_wdata[k], x_wdata[k]);
        chk($sformatf("m0_ack[%0d]", k), 32'(ack0[k]), 32'(e[k] == fin && !own[k]));
        chk($sformatf("m1_ack[%0d]", k), 32'(ack1[k]), 32'(e[k] == fin && own[k]));
        chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(e[k] != 0));
        chk($sformatf("m0_rdata[%0d]", k), rdata0[k], x_rd0[k]);
        chk($sformatf("m1_rdata[%0d]", k), rdata1[k], x_rd1[k]);
      end
    end
  end

  function automatic logic ack_of(input int k, input int m);
    return (m == 0) ? ack0[k] : ack1[k];
  endfunction

  task automatic start(input int k, input int m, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (m == 0) begin
      we0[k] = w; addr0[k] = a; wdata0[k] = d; req0[k] = 1'b1;
    end else begin
      we1[k] = w; addr1[k] = a; wdata1[k] = d; req1[k] = 1'b1;
    end
  endtask

  task automatic finish_req(input int k, input int m);
    @(posedge clk);
    #2;
    if (m == 0) req0[k] = 1'b0;
    else        req1[k] = 1'b0;
  endtask

  // Counts falling edges until the ack is seen; the count is the ack latency.
  task automatic wait_ack(input int k, input int m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack_of(k, m) && n < 40);
    if (!ack_of(k, m)) chk($sformatf("ack_timeout_%0d_%0d", k, m), 32'd0, 32'd1);
  endtask

  // Watches instance k for acks from either master; records who and when.
  task automatic scan_acks(input int k, input int want, output int who[4], output int at[4],
                           output int cnt);
    int n;
    n = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      who[i] = -1;
      at[i] = -1;
    end
    while (cnt < want && n < 60) begin
      @(negedge clk);
      n++;
      if (ack0[k] || ack1[k]) begin
        who[cnt] = ack1[k] ? 1 : 0;
        at[cnt]  = n;
        cnt++;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    int first;
    int who[4];
    int at[4];
    for (int k = 0; k < NInst; k++) begin
      req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
      addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
    end
    rst = 1'b0;
    @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_mem_en", 32'(mem_en[0]), 32'd0);
    chk("rst_rdata0", rdata0[0], 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Single read, MEM_WAIT=1.
    @(posedge clk); #2;
    start(0, 0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("rd_en_idle", 32'(mem_en[0]), 32'd0);
    @(negedge clk);
    chk("rd_en_issue", 32'(mem_en[0]), 32'd1);
    chk("rd_addr", mem_addr[0], 32'h10);
    wait_ack(0, 0, n);
    chk("rd_ack_lat", 32'(n + 2), 32'd4);
    chk("rd_rdata0", rdata0[0], 32'hDEADBEEF);
    chk("rd_rdata1", rdata1[0], 32'h0);
    finish_req(0, 0);

    // Loader write, MEM_WAIT=0.
    @(posedge clk); #2;
    start(1, 1, 1'b1, 32'h100, 32'h12345678);
    @(negedge clk);
    chk("wr_en_idle", 32'(mem_en[1]), 32'd0);
    @(negedge clk);
    chk("wr_en", 32'(mem_en[1]), 32'd1);
    chk("wr_we", 32'(mem_we[1]), 32'd1);
    chk("wr_addr", mem_addr[1], 32'h100);
    chk("wr_wdata", mem_wdata[1], 32'h12345678);
    wait_ack(1, 1, n);
    chk("wr_ack_lat", 32'(n + 2), 32'd3);
    chk("wr_en_once", 32'(mem_en[1]), 32'd0);
    chk("wr_rdata1", rdata1[1], 32'h0);
    finish_req(1, 1);

    // Read with no wait states.
    @(posedge clk); #2;
    start(1, 0, 1'b0, 32'h10, 32'h0);
    wait_ack(1, 0, n);
    chk("rd0_ack_lat", 32'(n), 32'd3);
    chk("rd0_rdata0", rdata0[1], 32'hDEADBEEF);
    finish_req(1, 0);

    // Reset during WAIT drops the access; a tie afterwards goes to m0.
    @(posedge clk); #2;
    start(0, 0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    start(0, 1, 1'b0, 32'h60, 32'h0);
    @(negedge clk);
    chk("mid_busy_wait", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("mid_ack0", 32'(ack0[0]), 32'd0);
    chk("mid_busy", 32'(busy[0]), 32'd0);
    chk("mid_addr", mem_addr[0], 32'h0);
    chk("mid_rdata0", rdata0[0], 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    scan_acks(0, 1, who, at, cnt);
    chk("mid_tie_who", 32'(who[0]), 32'd0);
    chk("mid_tie_at", 32'(at[0]), 32'd4);
    finish_req(0, 0);
    wait_ack(0, 1, n);
    chk("mid_m1_lat", 32'(n), 32'd4);
    chk("mid_m1_rdata", rdata1[0], 32'h5A5A0061);
    finish_req(0, 1);

    // Continuous tie from reset, MEM_WAIT=2.
    @(posedge clk); #2;
    rst = 1'b0;
    start(2, 0, 1'b0, 32'h200, 32'h0);
    start(2, 1, 1'b0, 32'h300, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    scan_acks(2, 4, who, at, cnt);
    chk("tie_cnt", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_who%0d", i), 32'(who[i]), 32'(i % 2));
      chk($sformatf("tie_at%0d", i), 32'(at[i]), 32'(5 + 5 * i));
    end
    @(posedge clk); #2;
    req0[2] = 1'b0;
    req1[2] = 1'b0;
    repeat (8) @(posedge clk);

    // m0 withdraws its request during ISSUE.
    @(posedge clk); #2;
    start(0, 0, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #2;
    req0[0] = 1'b0;
    cnt = 0;
    first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack0[0]) begin
        cnt++;
        if (first == 0) first = i;
      end
    end
    chk("wd_ack_cnt", 32'(cnt), 32'd1);
    chk("wd_ack_at", 32'(first), 32'd3);
    @(posedge clk); #2;
    start(0, 1, 1'b0, 32'h30, 32'h0);
    wait_ack(0, 1, n);
    chk("wd_m1_lat", 32'(n), 32'd4);
    chk("wd_m1_rdata", rdata1[0], 32'h5A5A0031);
    finish_req(0, 1);

    // m0 changes its address while the access is in flight.
    @(posedge clk); #2;
    start(0, 0, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("fl_addr_issue", mem_addr[0], 32'h40);
    @(posedge clk); #2;
    addr0[0] = 32'h44;
    @(negedge clk);
    chk("fl_addr_wait", mem_addr[0], 32'h40);
    @(negedge clk);
    chk("fl_ack", 32'(ack0[0]), 32'd1);
    chk("fl_addr_resp", mem_addr[0], 32'h40);
    chk("fl_rdata", rdata0[0], 32'h5A5A0041);
    finish_req(0, 0);
    @(negedge clk);
    chk("fl_addr_idle", mem_addr[0], 32'h40);
    @(posedge clk); #2;
    start(0, 1, 1'b1, 32'h50, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    chk("fl_next_addr", mem_addr[0], 32'h50);
    chk("fl_next_we", 32'(mem_we[0]), 32'd1);
    chk("fl_next_wdata", mem_wdata[0], 32'hCAFEF00D);
    wait_ack(0, 1, n);
    chk("fl_next_lat", 32'(n + 2), 32'd4);
    finish_req(0, 1);

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

endmodule
